// File: rtl/mdclcg_stream_gen_pkg.sv
// mdclcg_stream_gen_pkg: shared state encoding, default LCG constants and a counter-width helper
package mdclcg_stream_gen_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_e;
  localparam int R1_DEF = 6;
  localparam int R2_DEF = 5;
  localparam int R3_DEF = 4;
  localparam int R4_DEF = 2;
  localparam int B1_DEF = 43;
  localparam int B2_DEF = 19;
  localparam int B3_DEF = 23;
  localparam int B4_DEF = 59;
  localparam int WARMUP_DEF = 8;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mdclcg_stream_gen_if.sv
// mdclcg_stream_gen_if: seed/config inputs and valid/ready output stream of the generator
// master: generator side (drives out_data/out_valid/busy)
// slave:  seed source / consumer side (drives seeds, seed_load, enable, out_ready)
interface mdclcg_stream_gen_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 32
);
  logic             seed_load;
  logic [WIDTH-1:0] seed_x;
  logic [WIDTH-1:0] seed_y;
  logic [WIDTH-1:0] seed_p;
  logic [WIDTH-1:0] seed_q;
  logic             enable;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  modport master (
    input  seed_load, seed_x, seed_y, seed_p, seed_q, enable, out_ready,
    output out_data, out_valid, busy
  );
  modport slave (
    output seed_load, seed_x, seed_y, seed_p, seed_q, enable, out_ready,
    input  out_data, out_valid, busy
  );
endinterface

// File: rtl/mdclcg_stream_gen_lcg_step.sv
// mdclcg_lcg_step: one shift-add LCG step, s_o = s_i + (s_i << R) + B mod 2^WIDTH
// s_i: current state, s_o: next state
module mdclcg_lcg_step #(
  parameter int WIDTH = 32,
  parameter int R     = 6,
  parameter int B     = 43
) (
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] s_o
);
  localparam logic [WIDTH-1:0] INC = WIDTH'(B);
  assign s_o = s_i + ((R >= WIDTH) ? '0 : (s_i << R)) + INC;
endmodule

// File: rtl/mdclcg_stream_gen.sv
// mdclcg_stream_gen: modified dual-CLCG random bit generator packed into OUT_W-bit valid/ready words
// clk/rst: clock and synchronous active-high reset
// bus (master): seed_load + seeds + enable in, out_data/out_valid/busy out, out_ready in
module mdclcg_stream_gen
  import mdclcg_stream_gen_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OUT_W  = 32,
  parameter int R1     = R1_DEF,
  parameter int R2     = R2_DEF,
  parameter int R3     = R3_DEF,
  parameter int R4     = R4_DEF,
  parameter int B1     = B1_DEF,
  parameter int B2     = B2_DEF,
  parameter int B3     = B3_DEF,
  parameter int B4     = B4_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input logic                clk,
  input logic                rst,
  mdclcg_stream_gen_if.master bus
);
  localparam int CNT_W = cnt_w(OUT_W);
  localparam int WC_W  = cnt_w(WARMUP + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, y_q, p_q, q_q, x_d, y_d, p_d, q_d, x_n, y_n, p_n, q_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [OUT_W-1:0] pack_q, pack_d, data_q, data_d, word;
  logic             valid_q, valid_d, z, full, step, adv;
  mdclcg_lcg_step #(.WIDTH(WIDTH), .R(R1), .B(B1)) u_x (.s_i(x_q), .s_o(x_n));
  mdclcg_lcg_step #(.WIDTH(WIDTH), .R(R2), .B(B2)) u_y (.s_i(y_q), .s_o(y_n));
  mdclcg_lcg_step #(.WIDTH(WIDTH), .R(R3), .B(B3)) u_p (.s_i(p_q), .s_o(p_n));
  mdclcg_lcg_step #(.WIDTH(WIDTH), .R(R4), .B(B4)) u_q (.s_i(q_q), .s_o(q_n));
  assign z    = y_q[0] ? (x_q > y_q) : (p_q > q_q);
  assign full = cnt_q == CNT_W'(OUT_W - 1);
  // a full packer may not complete another word while the previous one is still held
  assign step = (state_q == ST_RUN) && bus.enable && !(valid_q && !bus.out_ready && full);
  assign adv  = (state_q == ST_WARMUP) || step;
  assign word = pack_q | (OUT_W'(z) << cnt_q);
  always_comb begin
    state_d = state_q;
    x_d     = adv ? x_n : x_q;
    y_d     = adv ? y_n : y_q;
    p_d     = adv ? p_n : p_q;
    q_d     = adv ? q_n : q_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    pack_d  = pack_q;
    data_d  = data_q;
    valid_d = valid_q && !bus.out_ready;
    if (state_q == ST_WARMUP) begin
      wc_d    = wc_q - 1'b1;
      state_d = (wc_q == WC_W'(1)) ? ST_RUN : ST_WARMUP;
    end
    if (step) begin
      pack_d  = full ? '0 : word;
      cnt_d   = full ? '0 : cnt_q + 1'b1;
      data_d  = full ? word : data_q;
      valid_d = full || valid_d;
    end
    if (bus.seed_load) begin
      x_d     = bus.seed_x;
      y_d     = bus.seed_y;
      p_d     = bus.seed_p;
      q_d     = bus.seed_q;
      cnt_d   = '0;
      pack_d  = '0;
      valid_d = 1'b0;
      wc_d    = WC_W'(WARMUP);
      state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      wc_q    <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_mdclcg_stream_gen.sv
// tb_mdclcg_stream_gen: scoreboard bench for mdclcg_stream_gen over three parameter sets
module tb_mdclcg_stream_gen;
  import mdclcg_stream_gen_pkg::*;
  localparam int NW = 700;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mdclcg_stream_gen_if #(.WIDTH(32), .OUT_W(2))  ifs ();
  mdclcg_stream_gen_if #(.WIDTH(32), .OUT_W(32)) ifl ();
  mdclcg_stream_gen_if #(.WIDTH(32), .OUT_W(32)) ifw ();
  mdclcg_stream_gen #(.OUT_W(2), .WARMUP(0)) dut_s (.clk(clk), .rst(rst), .bus(ifs));
  mdclcg_stream_gen                          dut_l (.clk(clk), .rst(rst), .bus(ifl));
  mdclcg_stream_gen #(.OUT_W(32), .WARMUP(1)) dut_w (.clk(clk), .rst(rst), .bus(ifw));
  int total = 0;
  int bad = 0;
  int nl = 0;
  logic [1:0]  qs[$];
  logic [31:0] ql[$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic mword(input int ow, inout logic [31:0] x, inout logic [31:0] y,
                       inout logic [31:0] p, inout logic [31:0] q, output logic [63:0] w);
    w = '0;
    for (int i = 0; i < ow; i++) begin
      w[i] = y[0] ? (x > y) : (p > q);
      x = x * 32'd65 + 32'd43;
      y = y * 32'd33 + 32'd19;
      p = p * 32'd17 + 32'd23;
      q = q * 32'd5 + 32'd59;
    end
  endtask
  task automatic load_s(input logic [31:0] sx, input logic [31:0] sy, input logic [31:0] sp,
                        input logic [31:0] sq);
    logic [31:0] x, y, p, q;
    logic [63:0] w;
    x = sx; y = sy; p = sp; q = sq;
    ifs.seed_x = sx; ifs.seed_y = sy; ifs.seed_p = sp; ifs.seed_q = sq;
    ifs.seed_load = 1'b1;
    @(posedge clk); #1;
    ifs.seed_load = 1'b0;
    qs.delete();
    for (int i = 0; i < 64; i++) begin
      mword(2, x, y, p, q, w);
      qs.push_back(w[1:0]);
    end
  endtask
  always @(negedge clk) begin
    if (ifs.out_valid && ifs.out_ready) begin
      if (qs.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s_extra: got %0h want no word", ifs.out_data);
      end else chk("s_word", 64'(ifs.out_data), 64'(qs.pop_front()));
    end
    if (ifl.out_valid && ifl.out_ready) begin
      nl++;
      if (ql.size() == 0) begin
        total++;
        bad++;
        $display("FAIL l_extra: got %0h want no word", ifl.out_data);
      end else chk("l_word", 64'(ifl.out_data), 64'(ql.pop_front()));
    end
  end
  initial begin
    logic [31:0] x, y, p, q;
    logic [63:0] w;
    int cyc;
    ifs.seed_load = 0; ifs.seed_x = 0; ifs.seed_y = 0; ifs.seed_p = 0; ifs.seed_q = 0;
    ifs.enable = 0; ifs.out_ready = 0;
    ifl.seed_load = 0; ifl.seed_x = 0; ifl.seed_y = 0; ifl.seed_p = 0; ifl.seed_q = 0;
    ifl.enable = 0; ifl.out_ready = 0;
    ifw.seed_load = 0; ifw.seed_x = 0; ifw.seed_y = 0; ifw.seed_p = 0; ifw.seed_q = 0;
    ifw.enable = 0; ifw.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(ifs.out_valid), 0);
    chk("rst_busy", 64'(ifs.busy), 0);
    chk("rst_data", 64'(ifs.out_data), 0);
    chk("rst_x", 64'(dut_s.x_q), 0);
    ifw.seed_x = 1; ifw.seed_y = 1; ifw.seed_p = 1; ifw.seed_q = 1;
    ifw.seed_load = 1'b1;
    @(posedge clk); #1;
    ifw.seed_load = 1'b0;
    chk("w_busy_warm", 64'(ifw.busy), 1);
    chk("w_state_warm", 64'(dut_w.state_q), 64'(ST_WARMUP));
    @(posedge clk); #1;
    chk("w_state_run", 64'(dut_w.state_q), 64'(ST_RUN));
    chk("w_x", 64'(dut_w.x_q), 108);
    chk("w_y", 64'(dut_w.y_q), 52);
    chk("w_p", 64'(dut_w.p_q), 40);
    chk("w_q", 64'(dut_w.q_q), 64);
    ifs.enable = 1'b1;
    ifs.out_ready = 1'b1;
    load_s(5, 3, 0, 0);
    chk("s_valid_c0", 64'(ifs.out_valid), 0);
    @(posedge clk); #1;
    chk("s_valid_c1", 64'(ifs.out_valid), 0);
    @(posedge clk); #1;
    chk("s_valid_c2", 64'(ifs.out_valid), 1);
    chk("s_first_word", 64'(ifs.out_data), 64'h1);
    ifs.out_ready = 1'b0;
    x = 5; y = 3; p = 0; q = 0;
    mword(2, x, y, p, q, w);
    mword(1, x, y, p, q, w);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("s_hold_data", 64'(ifs.out_data), 64'h1);
      chk("s_hold_valid", 64'(ifs.out_valid), 1);
    end
    chk("s_frozen_x", 64'(dut_s.x_q), 64'(x));
    chk("s_frozen_y", 64'(dut_s.y_q), 64'(y));
    x = 5; y = 3; p = 0; q = 0;
    mword(2, x, y, p, q, w);
    mword(2, x, y, p, q, w);
    ifs.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("s_word2_valid", 64'(ifs.out_valid), 1);
    chk("s_word2_data", 64'(ifs.out_data), 64'(w[1:0]));
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 10 && !ifs.out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("s_valid_pre_reseed", 64'(ifs.out_valid), 1);
    load_s(5, 3, 0, 0);
    chk("s_reseed_drop", 64'(ifs.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("s_reseed_valid", 64'(ifs.out_valid), 1);
    chk("s_reseed_word", 64'(ifs.out_data), 64'h1);
    ifs.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("s_prerst_valid", 64'(ifs.out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s_rst_valid", 64'(ifs.out_valid), 0);
    chk("s_rst_busy", 64'(ifs.busy), 0);
    chk("s_rst_data", 64'(ifs.out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    qs.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("s_idle_x", 64'(dut_s.x_q), 0);
    chk("s_idle_busy", 64'(ifs.busy), 0);
    chk("s_idle_valid", 64'(ifs.out_valid), 0);
    ifl.seed_x = 32'hdeadbeef; ifl.seed_y = 32'h12345678;
    ifl.seed_p = 32'hcafef00d; ifl.seed_q = 32'h0badc0de;
    ifl.seed_load = 1'b1;
    @(posedge clk); #1;
    ifl.seed_load = 1'b0;
    x = 32'hdeadbeef; y = 32'h12345678; p = 32'hcafef00d; q = 32'h0badc0de;
    mword(8, x, y, p, q, w);
    for (int i = 0; i < NW; i++) begin
      mword(32, x, y, p, q, w);
      ql.push_back(w[31:0]);
    end
    cyc = 0;
    while (nl < NW && cyc < 70000) begin
      ifl.enable = $urandom_range(0, 3) != 0;
      ifl.out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("l_count", 64'(nl), 64'(NW));
    chk("l_left", 64'(ql.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
